// File: rtl/ctrl_trace_pkg.sv
// Shared definitions for the control-word trace encoder.
// Holds the opcode values recovered by decode, the encoder state encoding,
// the bit offsets of the fields in a trace record, and the decode result type.
package ctrl_trace_pkg;

    localparam logic [5:0] OP_ADD     = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b000001;
    localparam logic [5:0] OP_SUB     = 6'b000010;
    localparam logic [5:0] OP_ORI     = 6'b010000;
    localparam logic [5:0] OP_AND     = 6'b010001;
    localparam logic [5:0] OP_OR      = 6'b010010;
    localparam logic [5:0] OP_MOVE    = 6'b100000;
    localparam logic [5:0] OP_SW      = 6'b100110;
    localparam logic [5:0] OP_LW      = 6'b100111;
    localparam logic [5:0] OP_BEQ     = 6'b110000;
    localparam logic [5:0] OP_HALT    = 6'b111111;
    localparam logic [5:0] OP_ILLEGAL = 6'b111110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    // Record layout: {pc, opcode, taken, ambig, illegal}
    localparam int REC_ILLEGAL = 0;
    localparam int REC_AMBIG   = 1;
    localparam int REC_TAKEN   = 2;
    localparam int REC_OP_LSB  = 3;
    localparam int REC_OP_W    = 6;
    localparam int REC_PC_LSB  = 9;

    typedef struct packed {
        logic [5:0] opcode;
        logic       taken;
        logic       ambig;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/ctrl_trace_encoder_if.sv
// Valid/ready drain port carrying trace records to the debug sink.
//   trace_valid : head record present (encoder -> sink)
//   trace_ready : sink accepts the head record (sink -> encoder)
//   trace_data  : head record, zero when nothing is buffered
interface ctrl_trace_encoder_if #(
    parameter int PC_W = 32
) ();
    logic            trace_valid;
    logic            trace_ready;
    logic [PC_W+8:0] trace_data;

    modport master (output trace_valid, output trace_data, input trace_ready);
    modport slave  (input trace_valid, input trace_data, output trace_ready);
endinterface

// File: rtl/trace_fifo.sv
// Small synchronous FIFO for trace records.
//   push_i/data_i : write request; accepted when not full or when popping
//   pop_i         : read request; ignored while empty
//   data_o        : head entry, zero when empty
//   full_o/empty_o: occupancy flags
module trace_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop, do_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    // A pop on the same edge frees the slot a full FIFO needs for the push.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ctrl_trace_encoder.sv
// Trace encoder: maps the CPU control word back to its opcode each cycle,
// tags branch outcome / ambiguity / illegal flags and buffers the record.
//   CLK, RST_n          : clock, async active-low reset
//   trace_en, pc        : sampling enable and PC of the executing instruction
//   Extsel..ALUOp       : control-unit outputs
//   trace               : valid/ready record port (master side)
//   halted              : encoder sits in HALTED
//   instr_cnt, drop_cnt : records generated / records lost to a full FIFO
module ctrl_trace_encoder
    import ctrl_trace_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              trace_en,
    input  logic [PC_W-1:0]   pc,
    input  logic              Extsel,
    input  logic              PCWre,
    input  logic              RegOut,
    input  logic              RegWre,
    input  logic              ALUSrcB,
    input  logic              ALUM2Reg,
    input  logic              PCSrc,
    input  logic              DataMemRW,
    input  logic [2:0]        ALUOp,
    ctrl_trace_encoder_if.master trace,
    output logic              halted,
    output logic [31:0]       instr_cnt,
    output logic [15:0]       drop_cnt
);
    localparam int REC_W = PC_W + 9;

    // Every non-halt rule also requires PCWre=1 so an unknown PCWre
    // falls through to illegal instead of matching a later rule.
    function automatic dec_t decode(input logic e, p, o, w, b, m, s, d,
                                    input logic [2:0] a);
        dec_t r;
        r.opcode  = OP_ILLEGAL;
        r.taken   = 1'b0;
        r.ambig   = 1'b0;
        r.illegal = 1'b1;
        if (p == 1'b0) begin
            r.opcode = OP_HALT; r.illegal = 1'b0;
        end else if (p == 1'b1 && d == 1'b1 && w == 1'b0 && b == 1'b1 && a == 3'b000) begin
            r.opcode = OP_SW; r.illegal = 1'b0;
        end else if (p == 1'b1 && m == 1'b1 && w == 1'b1 && b == 1'b1 && o == 1'b0 && a == 3'b000) begin
            r.opcode = OP_LW; r.illegal = 1'b0;
        end else if (p == 1'b1 && w == 1'b0 && b == 1'b0 && a == 3'b001 && (s == 1'b0 || s == 1'b1)) begin
            r.opcode = OP_BEQ; r.illegal = 1'b0; r.taken = s;
        end else if (p == 1'b1 && w == 1'b1 && o == 1'b1 && b == 1'b0 && m == 1'b0) begin
            r.illegal = 1'b0;
            case (a)
                3'b000:  begin r.opcode = OP_ADD; r.ambig = 1'b1; end  // identical to move
                3'b001:  r.opcode = OP_SUB;
                3'b100:  r.opcode = OP_AND;
                3'b011:  r.opcode = OP_OR;
                default: begin r.opcode = OP_ILLEGAL; r.illegal = 1'b1; end
            endcase
        end else if (p == 1'b1 && w == 1'b1 && o == 1'b0 && b == 1'b1 && m == 1'b0) begin
            if (a == 3'b000 && e == 1'b1) begin
                r.opcode = OP_ADDI; r.illegal = 1'b0;
            end else if (a == 3'b011 && e == 1'b0) begin
                r.opcode = OP_ORI; r.illegal = 1'b0;
            end
        end
        return r;
    endfunction

    state_e           state_q;
    logic             halted_q;
    logic [31:0]      instr_cnt_q;
    logic [15:0]      drop_cnt_q;
    dec_t             dec;
    logic [REC_W-1:0] rec;
    logic             gen, pop, full, empty, drop;

    always_comb begin
        dec = decode(Extsel, PCWre, RegOut, RegWre, ALUSrcB, ALUM2Reg, PCSrc,
                     DataMemRW, ALUOp);
        rec = '0;
        rec[REC_PC_LSB +: PC_W]   = pc;
        rec[REC_OP_LSB +: REC_OP_W] = dec.opcode;
        rec[REC_TAKEN]            = dec.taken;
        rec[REC_AMBIG]            = dec.ambig;
        rec[REC_ILLEGAL]          = dec.illegal;
        gen = 1'b0;
        if (trace_en == 1'b1) begin
            case (state_q)
                RUN:     gen = 1'b1;
                HALTED:  gen = (PCWre == 1'b1);
                default: gen = 1'b0;
            endcase
        end
    end

    assign trace.trace_valid = !empty;
    assign pop  = !empty && trace.trace_ready;
    assign drop = gen && full && !pop;

    trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_n_i (RST_n),
        .push_i  (gen),
        .data_i  (rec),
        .pop_i   (pop),
        .data_o  (trace.trace_data),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            halted_q    <= 1'b0;
            instr_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (trace_en != 1'b1) begin
                state_q  <= IDLE;
                halted_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                    RUN: begin
                        if (dec.opcode == OP_HALT) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end
                    end
                    HALTED: begin
                        if (PCWre == 1'b1) begin
                            state_q  <= RUN;
                            halted_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        halted_q <= 1'b0;
                    end
                endcase
            end
            if (gen) instr_cnt_q <= instr_cnt_q + 32'd1;
            if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign halted    = halted_q;
    assign instr_cnt = instr_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
